// File: rtl/spectrum_bin_writer.sv
// spectrum_bin_writer
//
// Purpose:
//   Collects one frame of SAMPLES unsigned bin magnitudes into a ping-pong pair
//   of register banks. Magnitudes are clamped to MAX_POWER before storage.
//   While one bank is being filled, the other is published on frequency_bins,
//   so the display never sees a partially written frame. A short frame
//   (mag_last before the final bin) has its remaining bins zeroed. A long frame
//   (no mag_last on the final bin) is published anyway. Both cases raise the
//   sticky frame_err.
//
// Ports:
//   clk            - single clock, rising edge
//   reset          - synchronous, active-high; clears both banks and all state
//   mag_in         - unsigned magnitude of the next bin (WIDTH bits)
//   mag_valid      - mag_in is valid
//   mag_last       - current sample is the last of its source frame
//   mag_ready      - block accepts a sample this cycle (FILL only)
//   frequency_bins - published bank, entry i is bin i
//   whichRAM       - index of the published bank
//   frame_done     - one-cycle pulse when a new bank is published
//   frame_err      - sticky flag, set by any frame whose length differed from SAMPLES

module spectrum_bin_writer #(
    parameter int SAMPLES   = 32,
    parameter int WIDTH     = 32,
    parameter int MAX_POWER = 100
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                mag_in,
    input  logic                            mag_valid,
    input  logic                            mag_last,
    output logic                            mag_ready,
    output logic [SAMPLES-1:0][WIDTH-1:0]   frequency_bins,
    output logic                            whichRAM,
    output logic                            frame_done,
    output logic                            frame_err
);

    localparam int IDX_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);
    localparam logic [WIDTH-1:0] CEILING  = WIDTH'(MAX_POWER);

    typedef enum logic [1:0] {
        FILL,
        ZERO,
        PUBLISH
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             which_q, which_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [1:0][SAMPLES-1:0][WIDTH-1:0] bank_q;

    logic             accept;
    logic             atLastIdx;
    logic             wrEn;
    logic [WIDTH-1:0] wrData;
    logic [WIDTH-1:0] clampedMag;

    // Handshake and clamp helpers shared by the next-state and output logic.
    // mag_ready is gated by reset so that nothing is offered as accepted while
    // reset is held, which also gives reset priority over an acceptance.
    assign mag_ready  = (state_q == FILL) && !reset;
    assign accept     = mag_valid && mag_ready;
    assign atLastIdx  = (wr_idx_q == LAST_IDX);
    assign clampedMag = (mag_in > CEILING) ? CEILING : mag_in;

    // State register plus the small control registers that travel with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FILL;
            wr_idx_q <= '0;
            which_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            which_q  <= which_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic. Reaching the final bin always publishes, whether or
    // not the source marked it last. An early mag_last diverts through ZERO,
    // which pads the rest of the write bank before publishing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: begin
                if (accept && atLastIdx) begin
                    state_d = PUBLISH;
                end else if (accept && mag_last) begin
                    state_d = ZERO;
                end
            end
            ZERO: begin
                if (atLastIdx) begin
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Output/datapath logic: write strobe into the hidden bank, index
    // advance, bank swap and error tracking. The index returns to 0 at the
    // final bin so it never exceeds SAMPLES-1, even for non-power-of-two
    // frame sizes.
    always_comb begin
        wr_idx_d = wr_idx_q;
        which_d  = which_q;
        done_d   = 1'b0;
        err_d    = err_q;
        wrEn     = 1'b0;
        wrData   = '0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    wrEn     = 1'b1;
                    wrData   = clampedMag;
                    wr_idx_d = atLastIdx ? '0 : wr_idx_q + 1'b1;
                    if (atLastIdx != mag_last) begin
                        err_d = 1'b1;
                    end
                end
            end
            ZERO: begin
                wrEn     = 1'b1;
                wrData   = '0;
                wr_idx_d = atLastIdx ? '0 : wr_idx_q + 1'b1;
            end
            PUBLISH: begin
                which_d  = ~which_q;
                done_d   = 1'b1;
                wr_idx_d = '0;
            end
            default: begin
                wr_idx_d = '0;
            end
        endcase
    end

    // Bank storage. Writes only ever land in the bank that is not displayed.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q <= '0;
        end else if (wrEn) begin
            bank_q[~which_q][wr_idx_q] <= wrData;
        end
    end

    assign frequency_bins = bank_q[which_q];
    assign whichRAM       = which_q;
    assign frame_done     = done_q;
    assign frame_err      = err_q;

endmodule

// File: tb/tb_spectrum_bin_writer.sv
// tb_spectrum_bin_writer
//
// Purpose:
//   Self-checking bench for spectrum_bin_writer with the default 32 x 32 bit
//   configuration and a ceiling of 100. A frame-level reference model collects
//   accepted samples in a queue. It decides from the frame length and the
//   mag_last flag when a publish is due, how many padding cycles precede it,
//   and what the displayed bank must then contain.

module tb_spectrum_bin_writer;

    localparam int SAMPLES = 32;
    localparam int WIDTH   = 32;
    localparam int MAXP    = 100;

    logic                          clk;
    logic                          reset;
    logic [WIDTH-1:0]              mag_in;
    logic                          mag_valid;
    logic                          mag_last;
    logic                          mag_ready;
    logic [SAMPLES-1:0][WIDTH-1:0] frequency_bins;
    logic                          whichRAM;
    logic                          frame_done;
    logic                          frame_err;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    logic [31:0] modelPub [SAMPLES];
    logic        modelWhich;
    logic        modelErr;
    logic [31:0] curFrame [$];

    typedef struct {
        logic [31:0] magIn;
        logic [31:0] expStored;
    } satVec_t;

    satVec_t satTable [8];

    spectrum_bin_writer #(
        .SAMPLES   (SAMPLES),
        .WIDTH     (WIDTH),
        .MAX_POWER (MAXP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mag_in         (mag_in),
        .mag_valid      (mag_valid),
        .mag_last       (mag_last),
        .mag_ready      (mag_ready),
        .frequency_bins (frequency_bins),
        .whichRAM       (whichRAM),
        .frame_done     (frame_done),
        .frame_err      (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] satModel(input logic [31:0] v);
        return (v > 32'(MAXP)) ? 32'(MAXP) : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Compares the whole displayed bank against the model's published frame
    task automatic checkBins(input string name);
        int bad;
        bad = -1;
        for (int i = SAMPLES - 1; i >= 0; i--) begin
            if (frequency_bins[i] !== modelPub[i]) bad = i;
        end
        testsRun++;
        if (bad >= 0) begin
            testsFailed++;
            $display("[TB] FAIL %s: bin %0d got %0h expected %0h at %0t",
                     name, bad, frequency_bins[bad], modelPub[bad], $time);
        end
    endtask

    // Padding cycles, then the publish cycle, then the swap
    task automatic expectPublish(input int zeroCycles);
        int n;
        for (int z = 0; z < zeroCycles; z++) begin
            checkBit("zero_ready", mag_ready, 1'b0);
            checkBit("zero_done", frame_done, 1'b0);
            checkBins("zero_bins");
            step();
        end
        checkBit("pub_ready", mag_ready, 1'b0);
        checkBit("pub_done_early", frame_done, 1'b0);
        checkBins("pub_bins_hold");
        step();
        n = curFrame.size();
        modelWhich = ~modelWhich;
        for (int i = 0; i < SAMPLES; i++) begin
            modelPub[i] = (i < n) ? curFrame[i] : 32'd0;
        end
        curFrame.delete();
        checkBit("pub_done", frame_done, 1'b1);
        checkBit("pub_which", whichRAM, modelWhich);
        checkBit("pub_err", frame_err, modelErr);
        checkBit("pub_ready_again", mag_ready, 1'b1);
        checkBins("pub_bins");
    endtask

    // Offers one sample after a stall of gap cycles and tracks it in the model
    task automatic applyStimulus(input logic [31:0] v, input logic last, input int gap);
        for (int g = 0; g < gap; g++) begin
            mag_valid = 1'b0;
            mag_in    = $urandom;
            mag_last  = 1'($urandom_range(0, 1));
            step();
            checkBit("stall_done", frame_done, 1'b0);
            checkBit("stall_ready", mag_ready, 1'b1);
            checkBins("stall_bins");
        end
        mag_valid = 1'b1;
        mag_in    = v;
        mag_last  = last;
        checkBit("accept_ready", mag_ready, 1'b1);
        step();
        mag_valid = 1'b0;
        mag_last  = 1'b0;
        checkBit("accept_done", frame_done, 1'b0);
        curFrame.push_back(satModel(v));
        if (curFrame.size() == SAMPLES) begin
            if (!last) modelErr = 1'b1;
            expectPublish(0);
        end else if (last) begin
            modelErr = 1'b1;
            expectPublish(SAMPLES - curFrame.size());
        end
    endtask

    task automatic doReset(input int cycles, input logic holdValid);
        reset     = 1'b1;
        mag_valid = holdValid;
        mag_in    = 32'd55;
        mag_last  = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            step();
            checkBit("rst_ready", mag_ready, 1'b0);
            checkBit("rst_done", frame_done, 1'b0);
        end
        reset     = 1'b0;
        mag_valid = 1'b0;
        #1;
        for (int i = 0; i < SAMPLES; i++) modelPub[i] = 32'd0;
        modelWhich = 1'b0;
        modelErr   = 1'b0;
        curFrame.delete();
        checkBit("rst_which", whichRAM, 1'b0);
        checkBit("rst_err", frame_err, 1'b0);
        checkBit("rst_ready_after", mag_ready, 1'b1);
        checkBins("rst_bins");
    endtask

    initial begin
        logic [31:0] v;
        logic        lst;

        reset     = 1'b1;
        mag_valid = 1'b0;
        mag_in    = '0;
        mag_last  = 1'b0;
        for (int i = 0; i < SAMPLES; i++) modelPub[i] = 32'd0;
        modelWhich = 1'b0;
        modelErr   = 1'b0;

        satTable[0] = '{32'd0,          32'd0};
        satTable[1] = '{32'd1,          32'd1};
        satTable[2] = '{32'd99,         32'd99};
        satTable[3] = '{32'd100,        32'd100};
        satTable[4] = '{32'd101,        32'd100};
        satTable[5] = '{32'd250,        32'd100};
        satTable[6] = '{32'hFFFF_FFFF,  32'd100};
        satTable[7] = '{32'h8000_0000,  32'd100};

        doReset(3, 1'b0);

        // Full back-to-back frame of ramp values
        for (int i = 0; i < SAMPLES; i++) begin
            applyStimulus(32'(i), (i == SAMPLES - 1), 0);
        end
        checkBit("full_which", whichRAM, 1'b1);
        checkBit("full_err", frame_err, 1'b0);
        checkOutput("full_bin31", frequency_bins[31], 32'd31);

        // Saturation vectors from the table, repeated across the frame
        for (int i = 0; i < SAMPLES; i++) begin
            applyStimulus(satTable[i % 8].magIn, (i == SAMPLES - 1), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < SAMPLES; i++) begin
            checkOutput($sformatf("sat_table_%0d", i), frequency_bins[i], satTable[i % 8].expStored);
        end
        checkBit("sat_which", whichRAM, 1'b0);

        // Short frame: last at index 9
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'd7, (i == 9), 0);
        end
        checkOutput("short_bin9", frequency_bins[9], 32'd7);
        checkOutput("short_bin10", frequency_bins[10], 32'd0);
        checkOutput("short_bin31", frequency_bins[31], 32'd0);
        checkBit("short_err", frame_err, 1'b1);

        // Long frame: 32 samples without last, then 33rd sample opens next frame
        doReset(1, 1'b0);
        for (int i = 0; i < SAMPLES; i++) begin
            applyStimulus(32'(i + 1), 1'b0, 0);
        end
        checkBit("long_err", frame_err, 1'b1);
        applyStimulus(32'd42, 1'b0, 0);
        for (int i = 1; i < SAMPLES; i++) begin
            applyStimulus(32'(i + 60), (i == SAMPLES - 1), 0);
        end
        checkOutput("long_carry_bin0", frequency_bins[0], 32'd42);
        checkOutput("long_carry_bin1", frequency_bins[1], 32'd61);

        // Reset at index 17 of frame 2, with a sample offered during reset
        doReset(1, 1'b0);
        for (int i = 0; i < SAMPLES; i++) begin
            applyStimulus(32'(i * 3), (i == SAMPLES - 1), 0);
        end
        for (int i = 0; i < 17; i++) begin
            applyStimulus(32'd9, 1'b0, 0);
        end
        doReset(2, 1'b1);
        for (int i = 0; i < SAMPLES; i++) begin
            applyStimulus(32'(i + 5), (i == SAMPLES - 1), 0);
        end
        checkBit("after_rst_which", whichRAM, 1'b1);
        checkOutput("after_rst_bin0", frequency_bins[0], 32'd5);

        // Reset in the middle of the padding phase
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'd11, 1'b0, 0);
        end
        mag_valid = 1'b1;
        mag_in    = 32'd11;
        mag_last  = 1'b1;
        step();
        mag_valid = 1'b0;
        mag_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checkBit("midzero_ready", mag_ready, 1'b0);
            checkBit("midzero_done", frame_done, 1'b0);
            step();
        end
        doReset(1, 1'b0);
        for (int c = 0; c < 30; c++) begin
            step();
            checkBit("midzero_no_pub", frame_done, 1'b0);
            checkBins("midzero_bins");
        end

        // Random stream with stalls, short, long and exact frames
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 120));
            if (curFrame.size() == SAMPLES - 1) begin
                lst = ($urandom_range(0, 3) != 0);
            end else begin
                lst = ($urandom_range(0, 15) == 0);
            end
            applyStimulus(v, lst, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
